lu_seq: RTL and testbench

LU_SEQ -- requirements
Module: lu_seq

---
 rtl/lu_seq.sv | 135 +++++++++++++
 tb/tb_lu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lu_seq.sv
// lu_seq: bit-serial logic unit.
// An accepted operation is evaluated one bit per clock through a single 1-bit
// logic function, LSB first. The result appears WIDTH cycles after the accept
// and is held until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   requester presents an operation
//   in_ready   high only in IDLE (operation can be accepted)
//   a, b       WIDTH-bit operands
//   sel        00 XOR, 01 XNOR, 10 OR, 11 NOR
//   s          WIDTH-bit result register
//   out_valid  high only in DONE (s holds a completed result)
//   out_ready  consumer accepts the result (only looked at in DONE)
//   busy       high only in RUN
module lu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       sel_reg;
  logic [WIDTH-1:0] s_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  // The single 1-bit logic unit, fed by the latched operand bits selected by
  // the bit counter.
  logic a_bit;
  logic b_bit;
  logic bit_res;

  assign a_bit = a_reg[cnt_reg];
  assign b_bit = b_reg[cnt_reg];

  always_comb begin
    bit_res = 1'b0;
    case (sel_reg)
      2'b00:   bit_res = a_bit ^ b_bit;
      2'b01:   bit_res = ~(a_bit ^ b_bit);
      2'b10:   bit_res = a_bit | b_bit;
      default: bit_res = ~(a_bit | b_bit);
    endcase
  end

  // Status outputs are registered and updated together with the state, so
  // each one is a clean decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      sel_reg       <= 2'b00;
      s_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg         <= a;
            b_reg         <= b;
            sel_reg       <= sel;
            s_reg         <= '0;
            cnt_reg       <= '0;
            state_reg     <= RUN;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        RUN: begin
          s_reg[cnt_reg] <= bit_res;
          if (cnt_reg == LAST_BIT) begin
            // Explicit wrap: WIDTH need not be a power of two.
            cnt_reg       <= '0;
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low on the release edge, so a new accept can only
          // happen one cycle after the result is taken.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign s         = s_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_lu_seq.sv
// Testbench for lu_seq (WIDTH=8): table of directed operations plus
// hand-written sequences for back-to-back flow, DONE back-pressure, input
// scrambling during RUN and asynchronous reset mid-operation.
module tb_lu_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic [WIDTH-1:0] s;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_checks;
  int n_fail;

  lu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at #1 after an edge while IDLE; accepts on the next edge.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vs);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = va; b = vb; sel = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("s_cleared", 32'(s), 32'd0);
    check("in_ready_run", 32'(in_ready), 32'd0);
  endtask

  // Walks the WIDTH RUN edges, checking the partially built result.
  task automatic finish_run(input logic [7:0] exp, input bit scramble);
    logic [7:0] mask;
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk); #1;
      mask = (k == WIDTH) ? 8'hFF : 8'((1 << k) - 1);
      check("s_partial", 32'(s), 32'(exp & mask));
      check("out_valid_run", 32'(out_valid), 32'(k == WIDTH));
      check("busy_run", 32'(busy), 32'(k < WIDTH));
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); sel = 2'($urandom);
        in_valid = 1'($urandom);
      end
    end
  endtask

  task automatic release_result(input logic [7:0] exp);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_release", 32'(in_ready), 32'd1);
    check("out_valid_release", 32'(out_valid), 32'd0);
    check("s_held_idle", 32'(s), 32'(exp));
  endtask

  initial begin
    int last_acc;
    int n_acc;
    bit prev_ov;
    bit drained;

    n_checks = 0; n_fail = 0;
    in_valid = 1'b0; a = '0; b = '0; sel = 2'b00; out_ready = 1'b0;

    vecs[0] = '{8'h0F, 8'h55, 2'b00, 8'h5A};
    vecs[1] = '{8'h0F, 8'h55, 2'b01, 8'hA5};
    vecs[2] = '{8'h0F, 8'h55, 2'b10, 8'h5F};
    vecs[3] = '{8'h0F, 8'h55, 2'b11, 8'hA0};
    vecs[4] = '{8'hA5, 8'h3C, 2'b00, 8'h99};
    vecs[5] = '{8'hA5, 8'h3C, 2'b01, 8'h66};
    vecs[6] = '{8'hA5, 8'h3C, 2'b10, 8'hBD};
    vecs[7] = '{8'hF0, 8'hCC, 2'b11, 8'h03};

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sel);
      finish_run(vecs[i].exp, 1'b0);
      release_result(vecs[i].exp);
      $display("op %0d: a=%02h b=%02h sel=%0d s=%02h exp=%02h", i, vecs[i].a, vecs[i].b,
               vecs[i].sel, s, vecs[i].exp);
    end

    // Back-to-back: out_ready and in_valid held high
    a = 8'h0F; b = 8'h55; sel = 2'b00;
    out_ready = 1'b1; in_valid = 1'b1;
    last_acc = -1; n_acc = 0; prev_ov = 1'b0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (in_ready) begin
        if (last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid) begin
        check("b2b_s", 32'(s), 32'h5A);
        check("b2b_ov_one_cycle", 32'(prev_ov), 32'd0);
      end
      prev_ov = out_valid;
      @(posedge clk); #1;
    end
    check("b2b_accepts", 32'(n_acc), 32'd4);
    $display("back-to-back: %0d accepts seen", n_acc);
    in_valid = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      @(posedge clk); #1;
      if (in_ready) drained = 1'b1;
    end
    check("drain_timeout", 32'(drained), 32'd1);
    out_ready = 1'b0;

    // Back-pressure in DONE with new operands on the bus
    start_op(8'h0F, 8'h55, 2'b01);
    finish_run(8'hA5, 1'b0);
    a = 8'h12; b = 8'h34; sel = 2'b00; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_s", 32'(s), 32'hA5);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_s", 32'(s), 32'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; end
    check("bp_second_result", 32'(s), 32'h26);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    release_result(8'h26);
    $display("back-pressure: s=%02h", s);

    // Inputs scrambled every cycle during RUN
    start_op(8'hFF, 8'h00, 2'b10);
    finish_run(8'hFF, 1'b1);
    release_result(8'hFF);
    $display("scramble: s=%02h", s);

    // Asynchronous reset mid-RUN (counter=3)
    start_op(8'h0F, 8'h55, 2'b00);
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_s", 32'(s), 32'd0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("arst_no_pulse", 32'(out_valid), 32'd0);
    end
    start_op(8'hF0, 8'hCC, 2'b11);
    finish_run(8'h03, 1'b0);
    release_result(8'h03);
    $display("after reset: s=%02h", s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
